// File: rtl/knn_topk_vote_if.sv
// Streaming distance/label input and inference result bundle for knn_topk_vote.
interface knn_topk_vote_if #(
  parameter int K      = 15,
  parameter int DIST_W = 32,
  parameter int TYPE_W = 3
);
  localparam int CNT_W = $clog2(K + 1);

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic [TYPE_W-1:0] in_type;
  logic              in_last;
  logic              busy;
  logic              done;
  logic [TYPE_W-1:0] inferred_type;
  logic [CNT_W-1:0]  inferred_votes;
  logic [CNT_W-1:0]  cand_count;

  modport slave (
    input  start, in_valid, in_dist, in_type, in_last,
    output in_ready, busy, done, inferred_type, inferred_votes, cand_count
  );

  modport master (
    output start, in_valid, in_dist, in_type, in_last,
    input  in_ready, busy, done, inferred_type, inferred_votes, cand_count
  );
endinterface

// File: rtl/knn_topk_vote.sv
// K-nearest-neighbour classifier back end: keeps the K smallest distances in a
// sorted insertion list, then runs a per-class majority vote with tie breaking.
module knn_topk_vote #(
  parameter int K        = 15,
  parameter int DIST_W   = 32,
  parameter int TYPE_W   = 3,
  parameter int TIE_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  knn_topk_vote_if.slave bus
);
  localparam int NC     = 1 << TYPE_W;
  localparam int CNT_W  = $clog2(K + 1);
  localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
  localparam int MAXI   = (K > NC) ? K : NC;
  localparam int IDX_W  = $clog2(MAXI);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_VOTE, S_RESOLVE, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [DIST_W-1:0] r_dist [K];
  logic [TYPE_W-1:0] r_type [K];
  logic [K-1:0]      r_valid;
  logic [CNT_W-1:0]  r_cnt   [NC];
  logic [SLOT_W-1:0] r_first [NC];
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cand, r_best_cnt, r_votes;
  logic [TYPE_W-1:0] r_best_cls, r_inf_type;
  logic [SLOT_W-1:0] r_best_first;
  logic              r_done;

  logic              w_start, w_accept;
  logic [K-1:0]      w_ins;
  logic [SLOT_W-1:0] w_slot;
  logic [TYPE_W-1:0] w_cls;
  logic              w_better;

  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_accept = (r_state == S_COLLECT) && bus.in_valid;
  assign w_slot   = r_idx[SLOT_W-1:0];
  assign w_cls    = r_idx[TYPE_W-1:0];

  // Strict compare keeps the earlier arrival ahead on equal distance; the
  // vector is monotone because the list is sorted with valid slots packed low.
  always_comb begin
    w_ins = '0;
    for (int i = 0; i < K; i++) begin
      w_ins[i] = !r_valid[i] || (bus.in_dist < r_dist[i]);
    end
  end

  always_comb begin
    w_better = 1'b0;
    if (r_cnt[w_cls] != '0) begin
      if (r_cnt[w_cls] > r_best_cnt) begin
        w_better = 1'b1;
      end else if ((TIE_MODE == 1) && (r_cnt[w_cls] == r_best_cnt) &&
                   (r_first[w_cls] < r_best_first)) begin
        w_better = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_COLLECT;
      S_COLLECT: if (bus.in_valid && bus.in_last) w_next = S_VOTE;
      S_VOTE:    if (r_idx == IDX_W'(K - 1)) w_next = S_RESOLVE;
      S_RESOLVE: if (r_idx == IDX_W'(NC - 1)) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Insertion list payload; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (w_ins[0]) begin
        r_dist[0] <= bus.in_dist;
        r_type[0] <= bus.in_type;
      end
      for (int i = 1; i < K; i++) begin
        if (w_ins[i]) begin
          r_dist[i] <= w_ins[i-1] ? r_dist[i-1] : bus.in_dist;
          r_type[i] <= w_ins[i-1] ? r_type[i-1] : bus.in_type;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_valid <= '0;
    end else if (w_accept) begin
      if (w_ins[0]) r_valid[0] <= 1'b1;
      for (int i = 1; i < K; i++) begin
        if (w_ins[i]) r_valid[i] <= w_ins[i-1] ? r_valid[i-1] : 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand       <= '0;
      r_idx        <= '0;
      r_best_cnt   <= '0;
      r_best_cls   <= '0;
      r_best_first <= '0;
      r_done       <= 1'b0;
      r_inf_type   <= '0;
      r_votes      <= '0;
      for (int c = 0; c < NC; c++) begin
        r_cnt[c]   <= '0;
        r_first[c] <= '0;
      end
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (bus.start) begin
            r_cand <= '0;
            for (int c = 0; c < NC; c++) begin
              r_cnt[c]   <= '0;
              r_first[c] <= '0;
            end
          end
        end
        S_COLLECT: begin
          r_idx <= '0;
          if (w_accept && (r_cand != CNT_W'(K))) r_cand <= r_cand + 1'b1;
        end
        S_VOTE: begin
          if (r_valid[w_slot]) begin
            r_cnt[r_type[w_slot]] <= r_cnt[r_type[w_slot]] + 1'b1;
            if (r_cnt[r_type[w_slot]] == '0) r_first[r_type[w_slot]] <= w_slot;
          end
          r_best_cnt   <= '0;
          r_best_cls   <= '0;
          r_best_first <= '1;
          r_idx <= (r_idx == IDX_W'(K - 1)) ? '0 : r_idx + 1'b1;
        end
        S_RESOLVE: begin
          if (w_better) begin
            r_best_cnt   <= r_cnt[w_cls];
            r_best_cls   <= w_cls;
            r_best_first <= r_first[w_cls];
          end
          r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_idx      <= '0;
          r_inf_type <= r_best_cls;
          r_votes    <= r_best_cnt;
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.in_ready       = (r_state == S_COLLECT);
  assign bus.busy           = (r_state == S_COLLECT) || (r_state == S_VOTE) ||
                              (r_state == S_RESOLVE);
  assign bus.done           = r_done;
  assign bus.inferred_type  = r_inf_type;
  assign bus.inferred_votes = r_votes;
  assign bus.cand_count     = r_cand;
endmodule

// File: doc/knn_topk_vote.md
KNN_TOPK_VOTE -- requirements
Module: knn_topk_vote

Interface
REQ-001 Parameter K, default 15, number of nearest neighbours kept (K >= 1).
REQ-002 Parameter DIST_W, default 32, width of a distance value (unsigned).
REQ-003 Parameter TYPE_W, default 3, label width; NUM_CLASSES = 2^TYPE_W.
REQ-004 Parameter TIE_MODE, default 0; 0 = lowest class index wins a tie, 1 = tied class owning the lowest-numbered slot wins.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begins a new inference; sampled in IDLE only.
REQ-008 in_valid  input  1  distance beat valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_dist  input  DIST_W  distance of one training vector to the input vector.
REQ-011 in_type  input  TYPE_W  label of that training vector.
REQ-012 in_last  input  1  marks the final beat of an inference.
REQ-013 busy  output  1  high in COLLECT, VOTE and RESOLVE.
REQ-014 done  output  1  one-cycle pulse when a result is ready.
REQ-015 inferred_type  output  TYPE_W  winning class.
REQ-016 inferred_votes  output  clog2(K+1)  vote count of the winning class.
REQ-017 cand_count  output  clog2(K+1)  number of valid neighbour slots.

Function
REQ-018 States SHALL be IDLE, COLLECT, VOTE, RESOLVE, DONE.
REQ-019 IDLE with start=1 SHALL clear all slot valid bits, clear cand_count, and go to COLLECT; start in any other state SHALL be ignored.
REQ-020 in_ready SHALL equal 1 exactly in COLLECT; beats with in_valid=1 outside COLLECT SHALL be ignored.
REQ-021 A beat is accepted when in_valid and in_ready are both 1; one beat per cycle, no stall.
REQ-022 Slots 0..K-1 SHALL hold (dist, type, valid), sorted ascending by dist, slot 0 nearest.
REQ-023 On accept: insert at the lowest slot i where the slot is invalid or in_dist < dist[i] (strict compare); slots i..K-2 shift to i+1; the old slot K-1 is dropped.
REQ-024 A beat with in_dist >= every dist of a full list SHALL be discarded; on equal distance the earlier arrival keeps the nearer slot.
REQ-025 cand_count SHALL saturate at K.
REQ-026 An accepted beat with in_last=1 SHALL be inserted, then the state SHALL go to VOTE on the next edge.
REQ-027 VOTE SHALL last exactly K cycles, visiting slot j in cycle j; a valid slot increments count[type]; on a 0->1 count transition, first_slot[type] = j.
REQ-028 RESOLVE SHALL last exactly NUM_CLASSES cycles, scanning class c in cycle c and keeping the running best.
REQ-029 In RESOLVE, a higher count SHALL always win; on equal count, TIE_MODE 0 SHALL keep the earlier class and TIE_MODE 1 SHALL take the class with the smaller first_slot.
REQ-030 Classes with count 0 SHALL never win.
REQ-031 DONE SHALL last 1 cycle with done=1, load inferred_type and inferred_votes, then return to IDLE.
REQ-032 inferred_type and inferred_votes SHALL hold their values until the next DONE or reset.
REQ-033 Latency: done SHALL be high in the cycle following the (K + NUM_CLASSES + 1)th rising edge after the edge that accepts the in_last beat.
REQ-034 Count registers SHALL be clog2(K+1) bits wide and cannot overflow.

Reset
REQ-035 rst=1 SHALL force IDLE, all slots invalid, all counts 0, and busy, done, in_ready, inferred_type, inferred_votes and cand_count to 0, in any state including mid-COLLECT, VOTE or RESOLVE.
REQ-036 A reset that interrupts an inference SHALL produce no done pulse; the next start SHALL run normally.

Verification (K=3, TYPE_W=2, DIST_W=8)
REQ-037 Reset: assert rst 2 cycles -> all outputs 0, in_ready 0.
REQ-038 Tie case: start, beats (50,t1)(10,t2)(30,t2)(20,t1)(5,t3)(40,t0,last) -> slots 5/t3, 10/t2, 20/t1; cand_count 3; TIE_MODE 0 gives type 1, TIE_MODE 1 gives type 3; votes 1; done 8 cycles after the last accept.
REQ-039 Majority case: beats (10,t2)(12,t2)(11,t1)(100,t0,last) -> type 2, votes 2.
REQ-040 Under-fill case: single beat (7,t3,last) -> cand_count 1, type 3, votes 1.
REQ-041 Equal distances: beats (10,t1)(10,t2)(10,t0)(10,t3,last) -> slots t1, t2, t0 (t3 discarded); TIE_MODE 0 gives type 0, TIE_MODE 1 gives type 1.
REQ-042 Reset mid-VOTE, then start and the REQ-039 stream -> no done before the reset, then a correct result of type 2; start pulses while busy have no effect.
